// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and bit-period helper.
// Imported by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  function automatic int unsigned bit_cyc(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial-line signals of the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx;
  logic              tx_busy;
  logic              tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BIT_CYC-1 while enabled and flags the last cycle of each bit.
module uart_baud_cnt #(
  parameter int unsigned BIT_CYC = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int unsigned CW   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign bit_end = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_W data bits LSB-first, optional parity, one stop bit.
// The line level is registered and always reflects the state being entered.
module uart_tx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY    = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  import uart_pkg::*;

  localparam int unsigned BIT_CYC  = uart_pkg::bit_cyc(CLK_FREQ, BAUD_RATE);
  localparam bit          HAS_PAR  = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
  localparam logic        ODD_PAR  = (PARITY == PAR_ODD);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_W - 1);

  if (DATA_W < 5 || DATA_W > 8) begin : g_bad_data_w
    $error("uart_tx: DATA_W must be in 5..8");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $warning("uart_tx: PARITY values above 2 are treated as no parity");
  end

  uart_tx_state_t    state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        idx_q, idx_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              bit_end;
  logic              cnt_clear;

  // Held cleared in IDLE; every other state change happens on bit_end, where the count wraps to 0.
  assign cnt_clear = (state_q == IDLE);

  uart_baud_cnt #(
    .BIT_CYC(BIT_CYC)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .enable (!cnt_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.tx_valid) begin
          state_d = START;
          shift_d = bus.tx_data;
          par_d   = (^bus.tx_data) ^ ODD_PAR;
          idx_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_BIT) begin
            if (HAS_PAR) begin
              state_d = uart_pkg::PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      uart_pkg::PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = (state_q == IDLE);
  assign bus.tx_busy  = (state_q != IDLE);
  assign bus.tx_done  = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no/odd/even parity) at 10 clocks per bit, checked every
// cycle against a frame-level model, plus literal frame checks and a serial loopback receiver.
module tb_uart_tx;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int          BC       = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d_data [3];
  logic [2:0] d_valid = '0;
  logic [2:0] o_tx, o_ready, o_busy, o_done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_if #(.DATA_W(8)) bus ();
    assign bus.tx_data  = d_data[g];
    assign bus.tx_valid = d_valid[g];
    assign o_tx[g]      = bus.tx;
    assign o_ready[g]   = bus.tx_ready;
    assign o_busy[g]    = bus.tx_busy;
    assign o_done[g]    = bus.tx_done;
    uart_tx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD),
      .DATA_W   (8),
      .PARITY   (g)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
  end

  // ---------------- frame-level model ----------------
  int          m_start [3] = '{-1, -1, -1};
  logic [11:0] m_bits  [3];
  int          m_len   [3];

  // Line levels of one frame, element k is the k-th bit on the wire.
  function automatic logic [11:0] frame_of(input int mode, input logic [7:0] d);
    logic [11:0] f;
    logic        p;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = d[k];
    if (mode != 0) begin
      p    = ^d;
      f[9] = (mode == 1) ? ~p : p;
    end
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_start[i] <= -1;
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 3; i++) begin
        if (m_start[i] < 0) begin
          if (d_valid[i]) begin
            m_start[i] <= cyc + 1;
            m_bits[i]  <= frame_of(i, d_data[i]);
            m_len[i]   <= (i == 0) ? 10 : 11;
          end
        end else if ((cyc + 1) - m_start[i] >= m_len[i] * BC) begin
          m_start[i] <= -1;
        end
      end
    end
  end

  // ---------------- per-cycle compare + loopback receiver ----------------
  logic       e_tx, e_rdy, e_busy, e_done;
  int         off;
  logic       rx_en  = 1'b0;
  logic       rx_act = 1'b0;
  int         rx_cnt, rx_k;
  logic [7:0] rx_sh, rx_exp;
  logic [7:0] rx_q [$];

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (m_start[i] < 0) begin
        e_tx = 1'b1; e_rdy = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end else begin
        off    = cyc - m_start[i];
        e_tx   = m_bits[i][off / BC];
        e_rdy  = 1'b0;
        e_busy = 1'b1;
        e_done = (off == m_len[i] * BC - 1);
      end
      vectors++;
      if ({o_tx[i], o_ready[i], o_busy[i], o_done[i]} !== {e_tx, e_rdy, e_busy, e_done}) begin
        miscompares++;
        $display("FAIL cycle unit%0d cyc%0d: tx,ready,busy,done = %b%b%b%b, required %b%b%b%b",
                 i, cyc, o_tx[i], o_ready[i], o_busy[i], o_done[i], e_tx, e_rdy, e_busy, e_done);
      end
    end
    if (!rx_en) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (o_tx[0] == 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % BC == BC / 2) begin
        rx_k = rx_cnt / BC;
        if (rx_k >= 1 && rx_k <= 8) begin
          rx_sh[rx_k-1] = o_tx[0];
        end else if (rx_k == 9) begin
          rx_act = 1'b0;
          vectors++;
          if (o_tx[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL loopback framing: stop bit %b, required 1", o_tx[0]);
          end else if (rx_q.size() == 0) begin
            miscompares++;
            $display("FAIL loopback extra byte: got 0x%02h, required no frame", rx_sh);
          end else begin
            rx_exp = rx_q.pop_front();
            if (rx_sh !== rx_exp) begin
              miscompares++;
              $display("FAIL loopback byte: got 0x%02h, required 0x%02h", rx_sh, rx_exp);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input bit keep, output int hs);
    int t;
    @(negedge clk);
    d_data[i]  = d;
    d_valid[i] = 1'b1;
    hs = -1;
    t  = 0;
    while (o_ready[i] !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (o_ready[i] !== 1'b1) begin
      miscompares++;
      $display("FAIL handshake unit%0d: tx_ready %b after 400 cycles, required 1", i, o_ready[i]);
      d_valid[i] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      hs = cyc;
      if (!keep) d_valid[i] = 1'b0;
    end
  endtask

  task automatic sample_frame(input int i, input int nbits, output logic [11:0] bits,
                              output int done_at);
    bits    = '0;
    done_at = 0;
    for (int c = 1; c <= nbits * BC; c++) begin
      @(negedge clk);
      if ((c - 1) % BC == BC / 2) bits[(c-1)/BC] = o_tx[i];
      if (o_done[i] && done_at == 0) done_at = c;
    end
  endtask

  logic [11:0] bits;
  int          dn, hs, hs1, hs2;
  logic [7:0]  b;

  initial begin
    for (int i = 0; i < 3; i++) d_data[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset tx",       int'(o_tx[0]),    1);
    chk("reset tx_ready", int'(o_ready[0]), 1);
    chk("reset tx_busy",  int'(o_busy[0]),  0);
    chk("reset tx_done",  int'(o_done[0]),  0);
    #2 rst_n = 1'b1;

    send(0, 8'hA5, 1'b0, hs);
    sample_frame(0, 10, bits, dn);
    chk("A5 line bits",   int'(bits), 12'h34A);
    chk("A5 done cycle",  dn, 100);

    send(2, 8'h07, 1'b0, hs);
    sample_frame(2, 11, bits, dn);
    chk("even 07 frame",      int'(bits), 12'h60E);
    chk("even 07 parity bit", int'(bits[9]), 1);
    chk("even frame length",  dn, 110);

    send(1, 8'h07, 1'b0, hs);
    sample_frame(1, 11, bits, dn);
    chk("odd 07 frame",      int'(bits), 12'h40E);
    chk("odd 07 parity bit", int'(bits[9]), 0);
    chk("odd frame length",  dn, 110);

    send(0, 8'h3C, 1'b1, hs1);
    d_data[0] = 8'hC3;
    send(0, 8'hC3, 1'b0, hs2);
    chk("back-to-back spacing", hs2 - hs1, 101);
    repeat (10 * BC + 2) @(negedge clk);

    send(0, 8'h00, 1'b0, hs);
    fork
      sample_frame(0, 10, bits, dn);
      begin
        repeat (35) @(negedge clk);
        d_data[0]  = 8'hFF;
        d_valid[0] = 1'b1;
        @(negedge clk);
        d_valid[0] = 1'b0;
      end
    join
    chk("ignored FF, 00 frame", int'(bits), 12'h200);
    repeat (3) @(negedge clk);

    send(0, 8'h55, 1'b0, hs);
    repeat (5 * BC + 5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-frame reset tx",      int'(o_tx[0]),   1);
    chk("mid-frame reset tx_busy", int'(o_busy[0]), 0);
    chk("mid-frame reset tx_done", int'(o_done[0]), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    send(0, 8'hA5, 1'b0, hs);
    sample_frame(0, 10, bits, dn);
    chk("post-reset A5 bits", int'(bits), 12'h34A);
    chk("post-reset A5 done", dn, 100);

    @(negedge clk);
    rx_en = 1'b1;
    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom_range(0, 255));
      rx_q.push_back(b);
      send(0, b, 1'b0, hs);
    end
    repeat (12 * BC) @(negedge clk);
    chk("loopback bytes outstanding", rx_q.size(), 0);
    rx_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
